// File: rtl/dt_ridge.sv
// dt_ridge: ridge (local-maximum) detector for a 128x128 8-bit distance map.
// Reads each pixel and its in-image 4-neighbours from the result RAM. It then
// writes a packed 1-bit skeleton image of 1024 x 16-bit words, where bit p[3:0]
// of word p[13:4] holds pixel p. It also reports the map maximum and the
// number of ridge pixels.
// Ports:
//   clk, reset (async, active-low)
//   start            : one-cycle run request, ignored while busy
//   busy, done       : run in progress / one-cycle completion pulse
//   res_rd/addr/di   : distance-map read port, data valid the cycle after res_rd
//   ske_wr/addr/do   : skeleton word write port
//   max_dist         : largest distance seen in the last run
//   ridge_cnt        : ridge pixels found in the last run
module dt_ridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        ske_wr,
  output logic [9:0]  ske_addr,
  output logic [15:0] ske_do,
  output logic [7:0]  max_dist,
  output logic [14:0] ridge_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_C_ADDR, S_C_DATA, S_N_ADDR, S_N_DATA, S_WRITE, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [13:0] r_p;
  logic [15:0] r_word;
  logic [7:0]  r_c;
  logic [7:0]  r_max;
  logic [14:0] r_cnt;
  logic [3:0]  r_nmask;   // neighbours still to read: bit0 N, bit1 W, bit2 E, bit3 S
  logic        r_ok;      // centre >= every neighbour read so far

  logic [6:0]  w_row, w_col;
  logic [3:0]  w_present;
  logic [3:0]  w_nmask_rest;
  logic [13:0] w_naddr;
  logic        w_last_in_word;
  logic        w_fin;
  logic        w_bit;

  assign w_row          = r_p[13:7];
  assign w_col          = r_p[6:0];
  assign w_present      = {w_row != 7'd127, w_col != 7'd127, w_col != 7'd0, w_row != 7'd0};
  // Drop the lowest set bit: that neighbour has just been read.
  assign w_nmask_rest   = r_nmask & (r_nmask - 4'd1);
  assign w_last_in_word = (r_p[3:0] == 4'hF);
  assign max_dist       = r_max;
  assign ridge_cnt      = r_cnt;

  // Lowest remaining neighbour gives the N, W, E, S read order.
  always_comb begin
    if (r_nmask[0])      w_naddr = r_p - 14'd128;
    else if (r_nmask[1]) w_naddr = r_p - 14'd1;
    else if (r_nmask[2]) w_naddr = r_p + 14'd1;
    else                 w_naddr = r_p + 14'd128;
  end

  always_comb begin
    w_next   = r_state;
    w_fin    = 1'b0;
    w_bit    = 1'b0;
    res_rd   = 1'b0;
    res_addr = '0;
    ske_wr   = 1'b0;
    ske_addr = '0;
    ske_do   = '0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (start) w_next = S_C_ADDR;
      S_C_ADDR: begin
        res_rd   = 1'b1;
        res_addr = r_p;
        w_next   = S_C_DATA;
      end
      S_C_DATA: begin
        if (res_di == 8'd0) w_fin = 1'b1;
        else                w_next = S_N_ADDR;
      end
      S_N_ADDR: begin
        res_rd   = 1'b1;
        res_addr = w_naddr;
        w_next   = S_N_DATA;
      end
      S_N_DATA: begin
        if (w_nmask_rest == 4'd0) begin
          w_fin = 1'b1;
          w_bit = r_ok && (res_di <= r_c);
        end else begin
          w_next = S_N_ADDR;
        end
      end
      S_WRITE: begin
        ske_wr   = 1'b1;
        ske_addr = r_p[13:4];
        ske_do   = r_word;
        w_next   = (r_p == 14'h3FFF) ? S_DONE : S_C_ADDR;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_fin) w_next = w_last_in_word ? S_WRITE : S_C_ADDR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_word  <= '0;
      r_c     <= '0;
      r_max   <= '0;
      r_cnt   <= '0;
      r_nmask <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p    <= '0;
            r_word <= '0;
            r_max  <= '0;
            r_cnt  <= '0;
          end
        end
        S_C_DATA: begin
          r_c     <= res_di;
          r_nmask <= w_present;
          r_ok    <= 1'b1;
          if (res_di > r_max) r_max <= res_di;
        end
        S_N_DATA: begin
          r_nmask <= w_nmask_rest;
          if (res_di > r_c) r_ok <= 1'b0;
        end
        S_WRITE: begin
          r_word <= '0;
          if (r_p != 14'h3FFF) r_p <= r_p + 14'd1;
        end
        default: ;
      endcase
      if (w_fin) begin
        r_word[r_p[3:0]] <= w_bit;
        if (w_bit) r_cnt <= r_cnt + 15'd1;
        if (!w_last_in_word) r_p <= r_p + 14'd1;
      end
    end
  end

endmodule

// File: tb/tb_dt_ridge.sv
// Bench for dt_ridge: RAM model, whole-image reference model, per-cycle
// compare of the write/read ports, and literal checks on known patterns.
module tb_dt_ridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, res_rd, ske_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic [9:0]  ske_addr;
  logic [15:0] ske_do;
  logic [7:0]  max_dist;
  logic [14:0] ridge_cnt;

  always #5 clk = ~clk;

  dt_ridge dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .ske_wr(ske_wr), .ske_addr(ske_addr), .ske_do(ske_do),
    .max_dist(max_dist), .ridge_cnt(ridge_cnt)
  );

  logic [7:0] mem [16384];
  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: evaluated directly from the ridge definition over the map.
  logic [15:0] exp_w [1024];
  int exp_cnt, exp_max, exp_reads, exp_cycles;

  function automatic void build_model();
    exp_cnt = 0; exp_max = 0; exp_reads = 0; exp_cycles = 1024 + 1;
    for (int w = 0; w < 1024; w++) exp_w[w] = 16'h0;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        int v;
        int nb;
        bit ridge;
        v = int'(mem[r*128+c]);
        nb = 0;
        ridge = (v != 0);
        if (v > exp_max) exp_max = v;
        if (r > 0)   begin nb++; if (int'(mem[(r-1)*128+c]) > v) ridge = 0; end
        if (c > 0)   begin nb++; if (int'(mem[r*128+c-1])   > v) ridge = 0; end
        if (c < 127) begin nb++; if (int'(mem[r*128+c+1])   > v) ridge = 0; end
        if (r < 127) begin nb++; if (int'(mem[(r+1)*128+c]) > v) ridge = 0; end
        if (v == 0) nb = 0;
        exp_reads  += 1 + nb;
        exp_cycles += 2 + 2*nb;
        if (ridge) begin
          exp_cnt++;
          exp_w[(r*128+c)/16][c%16] = 1'b1;
        end
      end
    end
  endfunction

  bit          chk_en = 0;
  int          wr_idx, rd_cnt;
  logic [15:0] got [1024];

  always @(negedge clk) begin
    if (chk_en) begin
      if (ske_wr) begin
        check("ske_addr", ske_addr, wr_idx);
        check("ske_do", ske_do, exp_w[wr_idx % 1024]);
        got[ske_addr] = ske_do;
        wr_idx++;
      end else begin
        check("ske_idle_zero", {ske_addr, ske_do}, 0);
      end
      if (res_rd) rd_cnt++;
      else check("res_addr_idle_zero", res_addr, 0);
    end
  end

  // restart_at: cycle (after start) at which start is pulsed again; -2 means
  // the done cycle. reset_at: cycle at which reset aborts the run; -1 = never.
  task automatic run_scan(input int restart_at, input int reset_at, output int cycles);
    int n;
    int rs;
    n = 0;
    build_model();
    rs = (restart_at == -2) ? exp_cycles : restart_at;
    wr_idx = 0; rd_cnt = 0;
    for (int w = 0; w < 1024; w++) got[w] = 16'h0;
    @(negedge clk);
    start = 1'b1;
    chk_en = 1;
    do begin
      @(negedge clk);
      n++;
      start = (n == rs);
      if (n == 1) check("busy_after_start", busy, 1);
      if (n == reset_at) begin
        reset = 1'b0;
        chk_en = 0;
        #1;
        check("rst_ctrl", {busy, done, res_rd, ske_wr}, 0);
        check("rst_addr", {res_addr, ske_addr, ske_do}, 0);
        check("rst_stats", {max_dist, ridge_cnt}, 0);
        repeat (3) @(negedge clk);
        check("rst_hold", {busy, res_rd, ske_wr, max_dist, ridge_cnt}, 0);
        reset = 1'b1;
        cycles = n;
        return;
      end
    end while (!done && n < 40000);
    cycles = n;
    check("done_cycle", n, exp_cycles);
    check("ridge_cnt", ridge_cnt, exp_cnt);
    check("max_dist", max_dist, exp_max);
    check("write_count", wr_idx, 1024);
    check("read_count", rd_cnt, exp_reads);
    @(negedge clk);
    start = 1'b0;
    check("done_single_pulse", done, 0);
    check("busy_low_after_done", busy, 0);
    chk_en = 0;
  endtask

  initial begin
    int cyc;
    int pc;
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, res_rd, ske_wr}, 0);
    check("reset_data", {res_addr, ske_addr, ske_do, max_dist, ridge_cnt}, 0);
    reset = 1'b1;
    @(negedge clk);

    // All-zero map, with a stray start mid-scan.
    run_scan(5000, -1, cyc);
    check("allzero_cycles", cyc, 33793);
    check("allzero_ridge_cnt", ridge_cnt, 0);
    check("allzero_max_dist", max_dist, 0);

    // Single pixel, 3x3 block, corner plateau, random bottom rows.
    mem[5*128+7] = 8'd1;
    for (int r = 9; r <= 11; r++)
      for (int c = 9; c <= 11; c++) mem[r*128+c] = 8'd1;
    mem[10*128+10] = 8'd2;
    mem[0] = 8'd3;
    mem[1] = 8'd3;
    mem[128] = 8'd2;
    for (int i = 125*128; i < 16384; i++) mem[i] = 8'($urandom_range(0, 3));

    run_scan(-1, 700, cyc);
    run_scan(-2, -1, cyc);

    check("word40_single", got[40], 16'h0080);
    check("word72_block_top", got[72], 16'h0A00);
    check("word80_block_mid", got[80], 16'h0400);
    check("word88_block_bot", got[88], 16'h0A00);
    check("word0_corner", got[0], 16'h0003);
    check("word8_corner_below", got[8], 16'h0000);
    check("max_dist_lit", max_dist, 3);
    pc = 0;
    for (int w = 0; w < 1000; w++) pc += $countones(got[w]);
    check("fixed_region_ridges", pc, 8);
    for (int w = 1000; w < 1024; w++) pc += $countones(got[w]);
    check("ridge_cnt_vs_words", ridge_cnt, pc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
